// File: rtl/sbmips_pkg.sv
// Shared encodings for the SBMIPS stack-machine control unit.
// Latency: n/a (constants, types and a small helper only).
// Backpressure: n/a.
package sbmips_pkg;

   // Instruction opcodes, Inst[7:5]
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   // ALU operations; the low two opcode bits of ADD/SUB/AND/NOT map directly onto these
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

   // ALU A-input select
   localparam logic SRC1_PC  = 1'b0;
   localparam logic SRC1_STK = 1'b1;

   // ALU B-input select
   localparam logic [1:0] SRC2_B    = 2'b00;
   localparam logic [1:0] SRC2_ZERO = 2'b01;
   localparam logic [1:0] SRC2_ONE  = 2'b10;
   localparam logic [1:0] SRC2_STK  = 2'b11;

   // FSM state encoding: 15 states in one 4-bit space (4'd15 is unused)
   typedef logic [3:0] state_t;
   localparam state_t S_RST = 4'd0;
   localparam state_t S_IF  = 4'd1;
   localparam state_t S_ID  = 4'd2;
   localparam state_t S_A1  = 4'd3;
   localparam state_t S_A2  = 4'd4;
   localparam state_t S_A3  = 4'd5;
   localparam state_t S_N1  = 4'd6;
   localparam state_t S_N2  = 4'd7;
   localparam state_t S_P1  = 4'd8;
   localparam state_t S_P2  = 4'd9;
   localparam state_t S_Q1  = 4'd10;
   localparam state_t S_Q2  = 4'd11;
`ifndef SBMIPS_FAST_JMP_EN
   localparam state_t S_J   = 4'd12;
`endif
   localparam state_t S_Z1  = 4'd13;
   localparam state_t S_Z2  = 4'd14;

   // Full control word produced by the decoder
   typedef struct packed {
      logic       pc_src;
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       i_ld;
      logic       s_src;
      logic       push;
      logic       pop;
      logic       tos;
      logic       b_ld;
      logic       alu_src1;
      logic [1:0] alu_src2;
      logic [1:0] alu_op;
   } ctrl_t;

   // Two-operand ALU instructions share the A1/A2/A3 sequence
   function automatic logic is_alu2_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/sbmips_cu_dec.sv
// Moore output decoder: control word from current state and opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; opcode only matters in ID (fast JMP) and A3 (ALU op select).
// Build option: SBMIPS_FAST_JMP_EN folds the JMP PC load into ID.
module sbmips_cu_dec
   import sbmips_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] opcode,
   output ctrl_t      ctrl
);

   // Decode the control word; every field not named for a state stays 0
   always_comb begin
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.i_or_d   = 1'b0;
            ctrl.mem_read = 1'b1;
            ctrl.i_ld     = 1'b1;
            ctrl.alu_src1 = SRC1_PC;
            ctrl.alu_src2 = SRC2_ONE;
            ctrl.alu_op   = ALU_ADD;
            ctrl.pc_src   = 1'b0;
            ctrl.pc_write = 1'b1;
         end
         S_ID: begin
            ctrl.tos = 1'b1;
`ifdef SBMIPS_FAST_JMP_EN
            if (opcode == OP_JMP) begin
               ctrl.pc_src   = 1'b1;
               ctrl.pc_write = 1'b1;
            end
`endif
         end
         S_A1: begin
            ctrl.pop = 1'b1;
         end
         S_A2: begin
            ctrl.pop  = 1'b1;
            ctrl.b_ld = 1'b1;
         end
         S_A3: begin
            ctrl.alu_src1 = SRC1_STK;
            ctrl.alu_src2 = SRC2_B;
            ctrl.alu_op   = opcode[1:0];
            ctrl.s_src    = 1'b0;
            ctrl.push     = 1'b1;
         end
         S_N1: begin
            ctrl.pop = 1'b1;
         end
         S_N2: begin
            ctrl.alu_src1 = SRC1_STK;
            ctrl.alu_src2 = SRC2_ZERO;
            ctrl.alu_op   = ALU_NOT;
            ctrl.s_src    = 1'b0;
            ctrl.push     = 1'b1;
         end
         S_P1: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_P2: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.s_src    = 1'b1;
            ctrl.push     = 1'b1;
         end
         S_Q1: begin
            ctrl.pop = 1'b1;
         end
         S_Q2: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
         end
`ifndef SBMIPS_FAST_JMP_EN
         S_J: begin
            ctrl.pc_src   = 1'b1;
            ctrl.pc_write = 1'b1;
         end
`endif
         S_Z1: begin
            ctrl.tos = 1'b1;
         end
         S_Z2: begin
            // Stack top + 0 drives the zero flag; the stack itself is untouched
            ctrl.alu_src1      = SRC1_STK;
            ctrl.alu_src2      = SRC2_ZERO;
            ctrl.alu_op        = ALU_ADD;
            ctrl.pc_src        = 1'b1;
            ctrl.pc_write_cond = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/sbmips_cu.sv
// Multi-cycle Moore control unit for the SBMIPS 8-bit stack machine.
// Latency: 5 cycles ALU ops, 4 NOT/PUSH/POP/JZ, 3 JMP (2 with SBMIPS_FAST_JMP_EN).
// Backpressure: none; free-running, async active-low rst aborts any instruction.
module sbmips_cu
   import sbmips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] Inst,
   output logic       PCsrc,
   output logic       PCwrite,
   output logic       PCwriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Ild,
   output logic       Ssrc,
   output logic       Push,
   output logic       Pop,
   output logic       Tos,
   output logic       Bld,
   output logic       ALUsrc1,
   output logic [1:0] ALUsrc2,
   output logic [1:0] ALUop
);

   state_t     state_q;
   state_t     state_d;
   logic [2:0] opcode;
   ctrl_t      ctrl;
   logic       inst_addr_unused;

   assign opcode = Inst[7:5];

   // The address/target field feeds the datapath muxes directly, not the FSM
   assign inst_addr_unused = ^Inst[4:0];

   // State register; reset lands in RST, whose decode is all-zero outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the opcode is only consulted in ID
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST: state_d = S_IF;
         S_IF:  state_d = S_ID;
         S_ID: begin
            if (is_alu2_op(opcode)) begin
               state_d = S_A1;
            end else begin
               case (opcode)
                  OP_NOT:  state_d = S_N1;
                  OP_PUSH: state_d = S_P1;
                  OP_POP:  state_d = S_Q1;
`ifdef SBMIPS_FAST_JMP_EN
                  OP_JMP:  state_d = S_IF;
`else
                  OP_JMP:  state_d = S_J;
`endif
                  OP_JZ:   state_d = S_Z1;
                  default: state_d = S_IF;
               endcase
            end
         end
         S_A1:  state_d = S_A2;
         S_A2:  state_d = S_A3;
         S_A3:  state_d = S_IF;
         S_N1:  state_d = S_N2;
         S_N2:  state_d = S_IF;
         S_P1:  state_d = S_P2;
         S_P2:  state_d = S_IF;
         S_Q1:  state_d = S_Q2;
         S_Q2:  state_d = S_IF;
`ifndef SBMIPS_FAST_JMP_EN
         S_J:   state_d = S_IF;
`endif
         S_Z1:  state_d = S_Z2;
         S_Z2:  state_d = S_IF;
         default: state_d = S_RST;
      endcase
   end

   sbmips_cu_dec u_dec (
      .state  (state_q),
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign PCsrc       = ctrl.pc_src;
   assign PCwrite     = ctrl.pc_write;
   assign PCwriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.i_or_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign Ild         = ctrl.i_ld;
   assign Ssrc        = ctrl.s_src;
   assign Push        = ctrl.push;
   assign Pop         = ctrl.pop;
   assign Tos         = ctrl.tos;
   assign Bld         = ctrl.b_ld;
   assign ALUsrc1     = ctrl.alu_src1;
   assign ALUsrc2     = ctrl.alu_src2;
   assign ALUop       = ctrl.alu_op;

endmodule

// File: tb/tb_sbmips_cu.sv
// Self-checking bench for sbmips_cu against a per-instruction step table.
// Latency: checks every cycle of every instruction, including instruction length.
// Backpressure: n/a; honours SBMIPS_FAST_JMP_EN for the JMP expectation.
module tb_sbmips_cu;

   logic       clk;
   logic       rst;
   logic [7:0] Inst;
   logic       PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild;
   logic       Ssrc, Push, Pop, Tos, Bld, ALUsrc1;
   logic [1:0] ALUsrc2, ALUop;
   logic [16:0] obs;

   int tests_run;
   int tests_failed;

   // Output vector bit positions
   localparam logic [16:0] V_PCSRC = 17'h10000;
   localparam logic [16:0] V_PCW   = 17'h08000;
   localparam logic [16:0] V_PCWC  = 17'h04000;
   localparam logic [16:0] V_IORD  = 17'h02000;
   localparam logic [16:0] V_MR    = 17'h01000;
   localparam logic [16:0] V_MW    = 17'h00800;
   localparam logic [16:0] V_ILD   = 17'h00400;
   localparam logic [16:0] V_SSRC  = 17'h00200;
   localparam logic [16:0] V_PUSH  = 17'h00100;
   localparam logic [16:0] V_POP   = 17'h00080;
   localparam logic [16:0] V_TOS   = 17'h00040;
   localparam logic [16:0] V_BLD   = 17'h00020;
   localparam logic [16:0] V_SRC1  = 17'h00010;
   localparam logic [16:0] V_S2_0  = 17'h00004;  // ALUsrc2 = 01
   localparam logic [16:0] V_S2_1  = 17'h00008;  // ALUsrc2 = 10
   localparam logic [16:0] V_IF    = V_MR | V_ILD | V_PCW | V_S2_1;

   sbmips_cu dut (
      .clk         (clk),
      .rst         (rst),
      .Inst        (Inst),
      .PCsrc       (PCsrc),
      .PCwrite     (PCwrite),
      .PCwriteCond (PCwriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .Ild         (Ild),
      .Ssrc        (Ssrc),
      .Push        (Push),
      .Pop         (Pop),
      .Tos         (Tos),
      .Bld         (Bld),
      .ALUsrc1     (ALUsrc1),
      .ALUsrc2     (ALUsrc2),
      .ALUop       (ALUop)
   );

   assign obs = {PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild,
                 Ssrc, Push, Pop, Tos, Bld, ALUsrc1, ALUsrc2, ALUop};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles per instruction, by opcode class
   function automatic int inst_len(input logic [2:0] op);
      if (op <= 3'd2) return 5;
`ifdef SBMIPS_FAST_JMP_EN
      if (op == 3'd6) return 2;
`else
      if (op == 3'd6) return 3;
`endif
      return 4;
   endfunction

   // Expected control vector for step k (0 = fetch) of an instruction with opcode op
   function automatic logic [16:0] exp_vec(input logic [2:0] op, input int k);
      logic [16:0] v;
      v = '0;
      if (k == 0) begin
         v = V_IF;
      end else if (k == 1) begin
         v = V_TOS;
`ifdef SBMIPS_FAST_JMP_EN
         if (op == 3'd6) v = v | V_PCSRC | V_PCW;
`endif
      end else begin
         case (op)
            3'd0, 3'd1, 3'd2: begin
               if (k == 2) v = V_POP;
               if (k == 3) v = V_POP | V_BLD;
               if (k == 4) v = V_SRC1 | V_PUSH | {15'd0, op[1:0]};
            end
            3'd3: begin
               if (k == 2) v = V_POP;
               if (k == 3) v = V_SRC1 | V_S2_0 | V_PUSH | 17'h3;
            end
            3'd4: begin
               if (k == 2) v = V_IORD | V_MR;
               if (k == 3) v = V_IORD | V_MR | V_SSRC | V_PUSH;
            end
            3'd5: begin
               if (k == 2) v = V_POP;
               if (k == 3) v = V_IORD | V_MW;
            end
            3'd6: begin
               if (k == 2) v = V_PCSRC | V_PCW;
            end
            default: begin
               if (k == 2) v = V_TOS;
               if (k == 3) v = V_SRC1 | V_S2_0 | V_PCSRC | V_PCWC;
            end
         endcase
      end
      return v;
   endfunction

   // Runs one instruction starting at the negedge of an already-checked fetch cycle.
   // Inst carries the real instruction only in decode cycles; elsewhere it is noise.
   // Returns positioned at the negedge of the next fetch cycle.
   task automatic run_inst(input logic [7:0] inst);
      logic [2:0] op;
      logic       alu;
      int         k;
      bit         done;
      op   = inst[7:5];
      alu  = (op <= 3'd2);
      k    = 1;
      done = 0;
      while (!done && k < 12) begin
         @(posedge clk); #1;
         if (k == 1 || (alu && k == 4)) Inst = inst;
         else                           Inst = 8'($urandom);
         @(negedge clk);
         tests_run++;
         if (Push && Pop) begin
            tests_failed++;
            $display("FAIL push_pop_excl op=%0d step=%0d Push=%0b Pop=%0b required not both", op, k, Push, Pop);
         end
         tests_run++;
         if (MemRead && MemWrite) begin
            tests_failed++;
            $display("FAIL mem_rw_excl op=%0d step=%0d MemRead=%0b MemWrite=%0b required not both", op, k, MemRead, MemWrite);
         end
         if (Ild) begin
            done = 1;
            tests_run++;
            if (obs !== V_IF) begin
               tests_failed++;
               $display("FAIL fetch_vec op=%0d got=%h exp=%h", op, obs, V_IF);
            end
         end else begin
            tests_run++;
            if (obs !== exp_vec(op, k)) begin
               tests_failed++;
               $display("FAIL step_vec op=%0d step=%0d got=%h exp=%h", op, k, obs, exp_vec(op, k));
            end
            k++;
         end
      end
      tests_run++;
      if (!done || k != inst_len(op)) begin
         tests_failed++;
         $display("FAIL cycle_count op=%0d got=%0d exp=%0d done=%0b", op, k, inst_len(op), done);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      Inst = 8'($urandom);
      repeat (2) @(negedge clk);
      tests_run++;
      if (obs !== 17'd0) begin
         tests_failed++;
         $display("FAIL reset_held got=%h exp=0", obs);
      end
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (obs !== 17'd0) begin
         tests_failed++;
         $display("FAIL reset_state got=%h exp=0", obs);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (obs !== V_IF) begin
         tests_failed++;
         $display("FAIL first_fetch got=%h exp=%h", obs, V_IF);
      end
   endtask

   task automatic test_push();
      run_inst(8'h83);
   endtask

   task automatic test_sub();
      run_inst(8'h20);
   endtask

   task automatic test_jmp();
      run_inst(8'hC9);
   endtask

   task automatic test_jz();
      run_inst(8'hE4);
   endtask

   task automatic test_back_to_back();
      run_inst(8'h00);
      run_inst(8'h40);
      run_inst(8'h60);
      run_inst(8'hA7);
   endtask

   // Reset asserted in the middle of A2 of a SUB
   task automatic test_reset_abort();
      @(posedge clk); #1 Inst = 8'h20;
      @(negedge clk);
      @(posedge clk); #1 Inst = 8'($urandom);
      @(negedge clk);
      @(posedge clk); #1 Inst = 8'($urandom);
      @(negedge clk);
      tests_run++;
      if (obs !== (V_POP | V_BLD)) begin
         tests_failed++;
         $display("FAIL abort_a2 got=%h exp=%h", obs, V_POP | V_BLD);
      end
      #1 rst = 1'b0;
      #1;
      tests_run++;
      if (obs !== 17'd0) begin
         tests_failed++;
         $display("FAIL abort_async got=%h exp=0", obs);
      end
      @(posedge clk); #1;
      tests_run++;
      if (obs !== 17'd0) begin
         tests_failed++;
         $display("FAIL abort_hold got=%h exp=0", obs);
      end
      @(negedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (obs !== V_IF || Push !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_resume got=%h exp=%h Push=%0b", obs, V_IF, Push);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1000; i++) begin
         run_inst(8'($urandom));
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      Inst         = 8'h00;
      test_reset();
      test_push();
      test_sub();
      test_jmp();
      test_jz();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
